mac_row_array: RTL
==================

Name: mac_row_array

Overview:
- Parametrised successor to the single-lane accumulate unit: a row of NUM_PE multiply-accumulate processing elements (PEs) sharing one streamed B operand.
- B and the enable are skewed one register per PE, systolic style. Each PE multiplies its own A lane and accumulates the product.
- Adds signed/unsigned mode, optional saturation, sticky per-lane overflow flags and a result-valid indication after the pipeline drains.
- b_out/en_out chain rows into a 2-D array feeding the matrix-multiply datapath.

Parameters:
DATA_WIDTH, 8, width of A lanes and B operand
NUM_PE, 4, number of PEs in the row (>=2)
ACC_WIDTH, DATA_WIDTH*3, width of each accumulator

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  input beat valid; b_in is captured when en=1
clr  input  1  synchronous clear of accumulators, flags and skew pipeline
signed_mode  input  1  1: A, B and accumulators are two's complement; 0: unsigned
sat_en  input  1  1: saturate on overflow; 0: wrap
a_in  input  NUM_PE*DATA_WIDTH  lane k = a_in[k*DATA_WIDTH +: DATA_WIDTH], consumed by PE k
b_in  input  DATA_WIDTH  shared B operand
c_out  output  NUM_PE*ACC_WIDTH  lane k = accumulator of PE k
ovf  output  NUM_PE  sticky overflow flag per PE
c_valid  output  1  accumulators final, row drained
b_out  output  DATA_WIDTH  b_in delayed NUM_PE cycles, for the next row
en_out  output  1  en delayed NUM_PE cycles, for the next row

Behaviour:
- Reset (async, rst_n=0): all accumulators, ovf, c_valid, skew registers, b_out and en_out go to 0 immediately. All stay 0 until the first edge after release.
- Skew pipeline: registers b_pipe[k] and en_pipe[k] for k=0..NUM_PE-1.
  - b_pipe[0] <= b_in and en_pipe[0] <= en.
  - b_pipe[k] <= b_pipe[k-1] and en_pipe[k] <= en_pipe[k-1].
  - b_out = b_pipe[NUM_PE-1] and en_out = en_pipe[NUM_PE-1], a delay of NUM_PE cycles.
  - b_pipe shifts every cycle regardless of en.
- PE k update: when en_pipe[k]=1, acc[k] <= acc[k] + a_lane[k]*b_pipe[k].
  - a_lane[k] is sampled in that same cycle; the feeder supplies A already skewed.
  - A beat with en=1 in cycle t updates PE k at the end of cycle t+1+k.
- Arithmetic:
  - The product is 2*DATA_WIDTH bits, extended to ACC_WIDTH: sign-extended if signed_mode=1, else zero-extended.
  - The sum is formed at ACC_WIDTH+1 bits.
  - Unsigned overflow: the result exceeds 2^ACC_WIDTH-1.
  - Signed overflow: the result falls outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - On overflow, ovf[k] <= 1 (sticky until clr or reset).
  - If sat_en=1, acc clamps to the violated bound. If sat_en=0, acc keeps the low ACC_WIDTH bits.
  - signed_mode and sat_en are evaluated per PE in its update cycle. The feeder holds them static for a whole run.
- clr (priority over en):
  - At the edge: all acc and ovf go to 0, all en_pipe go to 0 (in-flight beats are dropped), and c_valid goes to 0.
  - b_pipe still shifts.
  - If en=1 in the same cycle as clr, that beat is dropped.
- c_valid:
  - Register; c_valid <= !clr && en==0 && en_pipe==0 && have_data.
  - have_data is set by any PE update and cleared by clr or reset.
  - After a last beat in cycle t: accumulators are final from cycle t+NUM_PE+1, and c_valid=1 from cycle t+NUM_PE+2.
  - c_valid drops the edge after en=1 (accumulation resumes on the existing values) or after clr.
- No state machine beyond have_data and c_valid. Gaps in en mid-run are legal: the row simply keeps accumulating, and c_valid may pulse if a gap exceeds NUM_PE+1 cycles.
- Async reset mid-drain: all state is lost, and c_valid is never raised for the aborted run.

Test Plan:
- NUM_PE=4, DATA_WIDTH=8, unsigned, en=1 in cycles 0..2, b_in=3, a lanes [1,2,3,4] -> c_out=[9,18,27,36], ovf=0, c_valid rises in cycle 8 and stays high.
- Signed one beat: a lane0=0x80, lane1=0x80, b=0x80 then b=0x7F in a separate run -> lane0 = +16384 (0x004000), then -16256 (0xFFC080) after clr.
- Unsigned 259 beats a=b=255: sat_en=1 -> every lane 0xFFFFFF, ovf=4'hF; sat_en=0 -> 64259 (0x00FB03), ovf=4'hF.
- clr together with en mid-run (2 beats accumulated, PE3 in flight) -> next cycle all c_out=0, ovf=0, c_valid=0, the in-flight beat is never applied, en_out stays 0.
- Chaining: b_in=1,2,3 with en=1 in cycles 0..2 -> b_out=1,2,3 and en_out=1 in cycles 4..6, en_out=0 otherwise.
- rst_n pulsed low asynchronously in cycle 5 of a drain -> c_out, ovf, b_out, en_out and c_valid are 0 at once, with no c_valid pulse after release.

Source files
------------

// File: rtl/mac_row_array.sv
// mac_row_array
//   A row of NUM_PE multiply-accumulate PEs sharing one streamed B operand.
//   B and the beat enable travel down a one-register-per-PE skew chain, so PE k
//   sees a beat issued in cycle t during cycle t+1+k and accumulates
//   a_lane[k]*b at the end of that cycle. The feeder presents A already skewed.
//
//   Beat handshake: en is a valid-only strobe. A beat is accepted in every
//   cycle where en=1 and clr=0. There is no ready, so the row never stalls the
//   feeder.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   en           beat valid; b_in is captured when en=1
//   clr          synchronous clear of accumulators, flags and in-flight beats
//   signed_mode  1: two's complement operands and accumulators, 0: unsigned
//   sat_en       1: clamp on overflow, 0: wrap
//   a_in         per-PE A lanes, lane k = a_in[k*DATA_WIDTH +: DATA_WIDTH]
//   b_in         shared B operand
//   c_out        per-PE accumulators, lane k = c_out[k*ACC_WIDTH +: ACC_WIDTH]
//   ovf          sticky overflow flag per PE
//   c_valid      accumulators final and the row has drained
//   b_out/en_out b_in/en delayed NUM_PE cycles, for chaining the next row
module mac_row_array #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           clr,
    input  logic                           signed_mode,
    input  logic                           sat_en,
    input  logic [NUM_PE*DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]          b_in,
    output logic [NUM_PE*ACC_WIDTH-1:0]    c_out,
    output logic [NUM_PE-1:0]              ovf,
    output logic                           c_valid,
    output logic [DATA_WIDTH-1:0]          b_out,
    output logic                           en_out
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    logic [DATA_WIDTH-1:0] b_pipe [NUM_PE];
    logic [NUM_PE-1:0]     en_pipe;
    logic                  have_data;

    // Skew chain. B shifts every cycle; only the enable chain is cleared by clr,
    // which is what drops in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PE; k++) b_pipe[k] <= '0;
            en_pipe <= '0;
        end else begin
            b_pipe[0] <= b_in;
            for (int k = 1; k < NUM_PE; k++) b_pipe[k] <= b_pipe[k-1];
            if (clr) en_pipe <= '0;
            else     en_pipe <= {en_pipe[NUM_PE-2:0], en};
        end
    end

    assign b_out  = b_pipe[NUM_PE-1];
    assign en_out = en_pipe[NUM_PE-1];

    // have_data remembers that at least one PE updated since the last clear,
    // so an idle row after reset/clr never reports a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_data <= 1'b0;
            c_valid   <= 1'b0;
        end else if (clr) begin
            have_data <= 1'b0;
            c_valid   <= 1'b0;
        end else begin
            if (|en_pipe) have_data <= 1'b1;
            c_valid <= !en && (en_pipe == '0) && have_data;
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        logic [DATA_WIDTH-1:0] a_lane;
        logic signed [PW-1:0]  prod_s;
        logic [PW-1:0]         prod_u;
        logic [SW-1:0]         prod_x;
        logic [SW-1:0]         acc_x;
        logic [SW-1:0]         sum;
        logic [ACC_WIDTH-1:0]  acc;
        logic [ACC_WIDTH-1:0]  acc_nxt;
        logic                  ovf_nxt;
        logic                  ovf_r;

        assign a_lane = a_in[k*DATA_WIDTH +: DATA_WIDTH];
        assign prod_s = PW'($signed(a_lane)) * PW'($signed(b_pipe[k]));
        assign prod_u = PW'(a_lane) * PW'(b_pipe[k]);

        // The sum is one bit wider than the accumulator; the extra bit tells
        // which bound was crossed.
        always_comb begin
            if (signed_mode) begin
                prod_x = SW'(prod_s);
                acc_x  = {acc[ACC_WIDTH-1], acc};
            end else begin
                prod_x = SW'(prod_u);
                acc_x  = {1'b0, acc};
            end
            sum = acc_x + prod_x;

            if (signed_mode) ovf_nxt = sum[SW-1] ^ sum[SW-2];
            else             ovf_nxt = sum[SW-1];

            acc_nxt = sum[ACC_WIDTH-1:0];
            if (ovf_nxt && sat_en) begin
                if (!signed_mode)  acc_nxt = '1;
                else if (sum[SW-1]) acc_nxt = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                else               acc_nxt = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc   <= '0;
                ovf_r <= 1'b0;
            end else if (clr) begin
                acc   <= '0;
                ovf_r <= 1'b0;
            end else if (en_pipe[k]) begin
                acc <= acc_nxt;
                if (ovf_nxt) ovf_r <= 1'b1;
            end
        end

        assign c_out[k*ACC_WIDTH +: ACC_WIDTH] = acc;
        assign ovf[k] = ovf_r;
    end

endmodule
